// File: rtl/hack_cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hack_cpu_ctrl_pkg
// Purpose : Shared definitions for the Hack CPU control/register stage:
//           sequencer state encoding and instruction-register bit-field
//           positions.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hack_cpu_ctrl_pkg;

  // Sequencer states, one instruction walks FETCH -> DECODE -> [MEMRD] ->
  // EXEC -> [MEMWR] (A-instructions leave straight from DECODE).
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEMWR  = 3'd4
  } state_t;

  // Instruction-register field positions
  localparam int c_IR_CI      = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int c_IR_ABIT    = 12;  // 1 = ALU y operand comes from M
  localparam int c_IR_COMP_HI = 11;  // {zx,nx,zy,ny,f,no}
  localparam int c_IR_COMP_LO = 6;
  localparam int c_IR_D1      = 5;   // dest A
  localparam int c_IR_D2      = 4;   // dest D
  localparam int c_IR_D3      = 3;   // dest M
  localparam int c_IR_J_HI    = 2;   // j1 (out < 0)
  localparam int c_IR_J_LO    = 0;   // j3 (out > 0)

endpackage : hack_cpu_ctrl_pkg
`default_nettype wire

// File: rtl/hack_jump_cond.sv
`default_nettype none
// ============================================================================
// Module  : hack_jump_cond
// Purpose : Combinational Hack jump-condition evaluation.
// Ports   : i_j    - jump bits {j1,j2,j3}: jump on <0, ==0, >0
//           i_zr   - ALU zero flag
//           i_ng   - ALU negative flag
//           o_jump - branch taken
// Revision: 1.0 - initial release
// ============================================================================
module hack_jump_cond (
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jump
);

  // The three conditions are mutually exclusive, so 111 is unconditional
  // and 000 never jumps.
  assign o_jump = (i_j[2] & i_ng) | (i_j[1] & i_zr) | (i_j[0] & ~i_ng & ~i_zr);

endmodule : hack_jump_cond
`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hack_cpu_ctrl
// Purpose : Multi-cycle Hack CPU control/register stage. Fetches, holds
//           A/D/PC/IR/M, drives an external ALU and writes results back.
// Ports   : clk, rst_n              - clock, async active-low reset
//           o_imem_*/i_imem_*       - instruction fetch req/ready handshake
//           o_dmem_*/i_dmem_*       - data memory req/ready handshake
//           o_alu_x/y/ctl           - ALU operands and {zx,nx,zy,ny,f,no}
//           i_alu_out/zr/ng         - ALU result and flags (same cycle)
//           o_pc/o_a_reg/o_d_reg    - architectural state (observe)
//           o_retire                - one-cycle pulse per completed instr
// Revision: 1.0 - initial release
// ============================================================================
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ready,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic [DATA_W-1:0] o_alu_x,
  output logic [DATA_W-1:0] o_alu_y,
  output logic [5:0]        o_alu_ctl,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_zr,
  input  logic              i_alu_ng,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_a_reg,
  output logic [DATA_W-1:0] o_d_reg,
  output logic              o_retire
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_m;
  logic [ADDR_W-1:0]   r_maddr;   // A captured at instruction start
  logic [DATA_W-1:0]   r_wdata;   // ALU result frozen for the M write
  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_jump;
  logic                w_retire;
  logic                w_unused;

  assign w_pc_inc = r_pc + ADDR_W'(1);   // wraps naturally at 2**ADDR_W
  assign w_unused = &{1'b0, r_ir[14:13]};

  hack_jump_cond u_jump (
    .i_j    (r_ir[c_IR_J_HI:c_IR_J_LO]),
    .i_zr   (i_alu_zr),
    .i_ng   (i_alu_ng),
    .o_jump (w_jump)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state and retire decode
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      ST_FETCH:  if (i_imem_ready) w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!r_ir[c_IR_CI]) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (r_ir[c_IR_ABIT]) begin
          w_state_nxt = ST_MEMRD;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_MEMRD:  if (i_dmem_ready) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (r_ir[c_IR_D3]) begin
          w_state_nxt = ST_MEMWR;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_MEMWR: begin
        if (i_dmem_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // Architectural and staging registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_ir    <= '0;
      r_m     <= '0;
      r_maddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_FETCH:  if (i_imem_ready) r_ir <= i_imem_rdata;
        ST_DECODE: begin
          r_maddr <= r_a[ADDR_W-1:0];
          if (!r_ir[c_IR_CI]) begin
            r_a  <= r_ir;
            r_pc <= w_pc_inc;
          end
        end
        ST_MEMRD:  if (i_dmem_ready) r_m <= i_dmem_rdata;
        ST_EXEC: begin
          if (r_ir[c_IR_D2]) r_d <= i_alu_out;
          if (r_ir[c_IR_D1]) r_a <= i_alu_out;
          // Jump target is A as it was before this instruction's own write
          r_pc    <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
          r_wdata <= i_alu_out;
        end
        default: ;
      endcase
    end
  end

  // While reset is held the sequencer sits in FETCH; the request is masked
  // so nothing is issued until reset is released.
  assign o_imem_req   = rst_n && (r_state == ST_FETCH);
  assign o_imem_addr  = r_pc;
  assign o_dmem_req   = (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  assign o_dmem_we    = (r_state == ST_MEMWR);
  assign o_dmem_addr  = r_maddr;
  assign o_dmem_wdata = r_wdata;
  assign o_alu_x      = r_d;
  assign o_alu_y      = r_ir[c_IR_ABIT] ? r_m : r_a;
  assign o_alu_ctl    = r_ir[c_IR_COMP_HI:c_IR_COMP_LO];
  assign o_pc         = r_pc;
  assign o_a_reg      = r_a;
  assign o_d_reg      = r_d;
  assign o_retire     = w_retire;

endmodule : hack_cpu_ctrl
`default_nettype wire
